// File: rtl/tap_lane_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tap_lane_engine: multi-lane falling-block tap game with BCD scoring.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tap_lane_engine #(
    parameter int          LANES        = 4,
    parameter int          DIGITS       = 4,
    parameter int          BLOCK_SIZE   = 15,
    parameter int          LANE_X0      = 15,
    parameter int          HIT_Y        = 104,
    parameter int          WINDOW       = 8,
    parameter int          MAX_MISSES   = 3,
    parameter logic [2:0]  BLOCK_COLOUR = 3'b111,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  tick,
    input  logic [LANES-1:0]      tap,
    output logic                  draw_valid,
    input  logic                  draw_ready,
    output logic [7:0]            draw_x,
    output logic [6:0]            draw_y,
    output logic [2:0]            draw_colour,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [7:0]            misses,
    output logic                  game_over
);

    localparam logic [6:0] c_HIT_Y   = 7'(HIT_Y);
    localparam logic [6:0] c_WIN_TOP = 7'(HIT_Y - WINDOW);
    localparam logic [7:0] c_MAX     = 8'(MAX_MISSES);
    localparam logic [3:0] c_LANES   = 4'(LANES);
    localparam logic [7:0] c_X0      = 8'(LANE_X0);
    localparam logic [7:0] c_PITCH   = 8'(BLOCK_SIZE);

    typedef enum logic [2:0] {
        S_SPAWN = 3'd0,
        S_DRAW  = 3'd1,
        S_WAIT  = 3'd2,
        S_ERASE = 3'd3,
        S_MOVE  = 3'd4,
        S_JUDGE = 3'd5,
        S_CLEAR = 3'd6,
        S_OVER  = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_lfsr;
    logic [2:0]            r_lane;
    logic [6:0]            r_y;
    logic                  r_hit;
    logic                  r_foul;
    logic [LANES-1:0]      r_tap_q;
    logic                  r_tick_pend;
    logic                  r_valid;
    logic [7:0]            r_x;
    logic [6:0]            r_dy;
    logic [2:0]            r_col;
    logic [4*DIGITS-1:0]   r_score;
    logic [7:0]            r_misses;

    logic                  w_xfer;
    logic                  w_step;
    logic [7:0]            w_lfsr_next;
    logic [2:0]            w_spawn_lane;
    logic [7:0]            w_spawn_x;
    logic [LANES-1:0]      w_edge;
    logic [LANES-1:0]      w_lane_mask;
    logic                  w_on;
    logic                  w_off;
    logic                  w_judging;
    logic                  w_in_window;
    logic                  w_hit_n;
    logic                  w_foul_n;
    logic                  w_all9;
    logic                  w_carry;
    logic [4*DIGITS-1:0]   w_score_inc;
    logic [4*DIGITS-1:0]   w_score_next;

    assign w_xfer       = r_valid & draw_ready;
    assign w_step       = r_tick_pend | tick;
    assign w_lfsr_next  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_spawn_lane = ({1'b0, r_lfsr[2:0]} < c_LANES) ? r_lfsr[2:0]
                                                           : r_lfsr[2:0] - c_LANES[2:0];
    assign w_spawn_x    = c_X0 + ({5'd0, w_spawn_lane} * c_PITCH);

    // A tap edge in the JUDGE cycle itself still counts, hence the _n forms.
    assign w_edge      = tap & ~r_tap_q;
    assign w_lane_mask = {{(LANES-1){1'b0}}, 1'b1} << r_lane;
    assign w_on        = |(w_edge & w_lane_mask);
    assign w_off       = |(w_edge & ~w_lane_mask);
    assign w_judging   = (r_state == S_DRAW) || (r_state == S_WAIT) || (r_state == S_ERASE)
                      || (r_state == S_MOVE) || (r_state == S_JUDGE);
    assign w_in_window = (r_y >= c_WIN_TOP);
    assign w_hit_n     = r_hit  | (w_judging & w_on & w_in_window);
    assign w_foul_n    = r_foul | (w_judging & (w_off | (w_on & ~w_in_window)));

    always_comb begin
        w_all9      = 1'b1;
        w_carry     = 1'b1;
        w_score_inc = r_score;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_score[4*d +: 4] != 4'd9) begin
                w_all9 = 1'b0;
            end
            if (w_carry) begin
                if (r_score[4*d +: 4] == 4'd9) begin
                    w_score_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*d +: 4] = r_score[4*d +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
        w_score_next = w_all9 ? r_score : w_score_inc;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_SPAWN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SPAWN: w_state_next = S_DRAW;
            S_DRAW:  if (w_xfer) w_state_next = S_WAIT;
            S_WAIT:  if (w_step) w_state_next = (r_y == c_HIT_Y) ? S_JUDGE : S_ERASE;
            S_ERASE: if (w_xfer) w_state_next = S_MOVE;
            S_MOVE:  w_state_next = S_DRAW;
            S_JUDGE: w_state_next = S_CLEAR;
            S_CLEAR: if (w_xfer) w_state_next = (r_misses == c_MAX) ? S_OVER : S_SPAWN;
            S_OVER:  w_state_next = S_OVER;
            default: w_state_next = S_SPAWN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_lfsr      <= LFSR_SEED;
            r_lane      <= 3'd0;
            r_y         <= 7'd0;
            r_hit       <= 1'b0;
            r_foul      <= 1'b0;
            r_tap_q     <= '0;
            r_tick_pend <= 1'b0;
            r_valid     <= 1'b0;
            r_x         <= 8'd0;
            r_dy        <= 7'd0;
            r_col       <= 3'b000;
            r_score     <= '0;
            r_misses    <= 8'd0;
        end else begin
            r_tap_q <= tap;
            r_hit   <= w_hit_n;
            r_foul  <= w_foul_n;
            if (tick && (r_state != S_WAIT) && (r_state != S_OVER)) begin
                r_tick_pend <= 1'b1;
            end
            case (r_state)
                S_SPAWN: begin
                    r_lane  <= w_spawn_lane;
                    r_lfsr  <= w_lfsr_next;
                    r_y     <= 7'd0;
                    r_hit   <= 1'b0;
                    r_foul  <= 1'b0;
                    r_valid <= 1'b1;
                    r_x     <= w_spawn_x;
                    r_dy    <= 7'd0;
                    r_col   <= BLOCK_COLOUR;
                end
                S_DRAW: begin
                    if (w_xfer) r_valid <= 1'b0;
                end
                S_WAIT: begin
                    if (w_step) begin
                        r_tick_pend <= 1'b0;
                        if (r_y != c_HIT_Y) begin
                            r_valid <= 1'b1;
                            r_dy    <= r_y;
                            r_col   <= 3'b000;
                        end
                    end
                end
                S_ERASE: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_y     <= r_y + 7'd1;
                    end
                end
                S_MOVE: begin
                    r_valid <= 1'b1;
                    r_dy    <= r_y;
                    r_col   <= BLOCK_COLOUR;
                end
                S_JUDGE: begin
                    if (w_hit_n && !w_foul_n) begin
                        r_score <= w_score_next;
                    end else begin
                        r_misses <= r_misses + 8'd1;
                    end
                    r_valid <= 1'b1;
                    r_dy    <= c_HIT_Y;
                    r_col   <= 3'b000;
                end
                S_CLEAR: begin
                    if (w_xfer) r_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign draw_valid  = r_valid;
    assign draw_x      = r_x;
    assign draw_y      = r_dy;
    assign draw_colour = r_col;
    assign score_bcd   = r_score;
    assign misses      = r_misses;
    assign game_over   = (r_state == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_tap_lane_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tap_lane_engine: directed self-checking bench for tap_lane_engine.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tap_lane_engine;

    localparam int LANES      = 4;
    localparam int DIGITS     = 3;
    localparam int HIT_Y      = 8;
    localparam int WINDOW     = 2;
    localparam int MAX_MISSES = 3;
    localparam int BLOCK_SIZE = 15;
    localparam int LANE_X0    = 15;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic                 tick;
    logic [LANES-1:0]     tap;
    logic                 draw_valid;
    logic                 draw_ready;
    logic [7:0]           draw_x;
    logic [6:0]           draw_y;
    logic [2:0]           draw_colour;
    logic [4*DIGITS-1:0]  score_bcd;
    logic [7:0]           misses;
    logic                 game_over;

    int         n_checks = 0;
    int         n_errors = 0;
    int         xfer_cnt = 0;
    int         n_clear  = 0;
    int         blk_y    = -1;
    int         spawn_x  = -1;
    int         base;
    int         l;
    bit         aborted  = 1'b0;
    logic [7:0] lfsr_m;

    tap_lane_engine #(
        .LANES      (LANES),
        .DIGITS     (DIGITS),
        .BLOCK_SIZE (BLOCK_SIZE),
        .LANE_X0    (LANE_X0),
        .HIT_Y      (HIT_Y),
        .WINDOW     (WINDOW),
        .MAX_MISSES (MAX_MISSES)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .tick        (tick),
        .tap         (tap),
        .draw_valid  (draw_valid),
        .draw_ready  (draw_ready),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_colour (draw_colour),
        .score_bcd   (score_bcd),
        .misses      (misses),
        .game_over   (game_over)
    );

    always #5 clock = ~clock;

    // Inputs only change 1 time unit after a posedge, so the negedge view
    // is exactly what the next posedge will see.
    always @(negedge clock) begin
        if (resetn && draw_valid && draw_ready) begin
            xfer_cnt++;
            if (draw_colour != 3'b000) begin
                blk_y = int'(draw_y);
                if (draw_y == 7'd0) spawn_x = int'(draw_x);
            end else if (draw_y == 7'(HIT_Y)) begin
                n_clear++;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: got checks=%0d required completion", n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int lane_of(input logic [7:0] s);
        int v;
        v = int'(s[2:0]);
        return (v < LANES) ? v : v - LANES;
    endfunction

    task automatic wait_clear(input int from);
        int k;
        k = 0;
        while (n_clear == from && k < 200) begin
            cyc(1);
            k++;
        end
        if (n_clear == from) begin
            check("clear_timeout", n_clear, from + 1);
            aborted = 1'b1;
        end
    endtask

    // Runs the live block to its clear; at_y < 0 means no tap at all.
    task automatic play_block(input int tap_lane, input int at_y);
        int start;
        int k;
        int lane;
        start = n_clear;
        lane  = lane_of(lfsr_m);
        k     = 0;
        if (at_y >= 0) begin
            while (blk_y != at_y && n_clear == start && k < 200) begin
                cyc(1);
                k++;
            end
            tap[tap_lane] = 1'b1;
        end
        wait_clear(start);
        tap = '0;
        check("spawn_x", spawn_x, LANE_X0 + lane * BLOCK_SIZE);
        lfsr_m = lfsr_next(lfsr_m);
    endtask

    initial begin
        resetn     = 1'b0;
        tick       = 1'b0;
        tap        = '0;
        draw_ready = 1'b0;
        lfsr_m     = 8'hA5;
        cyc(2);
        check("rst_valid",  draw_valid, 0);
        check("rst_xyc",    {draw_x, draw_y, draw_colour}, 0);
        check("rst_score",  score_bcd, 0);
        check("rst_misses", misses, 0);
        check("rst_over",   game_over, 0);

        resetn = 1'b1;
        cyc(1);
        check("first_req", {draw_valid, draw_x, draw_y, draw_colour}, {1'b1, 8'd30, 7'd0, 3'b111});
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("hold_req", {draw_valid, draw_x, draw_y, draw_colour}, {1'b1, 8'd30, 7'd0, 3'b111});
        end

        repeat (3) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
        base       = xfer_cnt;
        draw_ready = 1'b1;
        cyc(30);
        check("stall_xfers", xfer_cnt - base, 3);
        check("stall_y",     blk_y, 1);
        check("stall_idle",  draw_valid, 0);

        tick = 1'b1;
        l = lane_of(lfsr_m);
        play_block(l, 7);
        check("hit_score",  score_bcd, 12'h001);
        check("hit_misses", misses, 0);

        l = lane_of(lfsr_m);
        play_block(l, 3);
        check("early_misses", misses, 1);
        check("early_score",  score_bcd, 12'h001);

        l = lane_of(lfsr_m);
        play_block((l + 1) % LANES, 7);
        check("wrong_misses", misses, 2);
        check("wrong_score",  score_bcd, 12'h001);

        for (int i = 0; i < 98 && !aborted; i++) play_block(lane_of(lfsr_m), 7);
        check("score_099", score_bcd, 12'h099);
        if (!aborted) play_block(lane_of(lfsr_m), 7);
        check("score_100", score_bcd, 12'h100);
        for (int i = 0; i < 899 && !aborted; i++) play_block(lane_of(lfsr_m), 7);
        check("score_999", score_bcd, 12'h999);
        if (!aborted) play_block(lane_of(lfsr_m), 7);
        check("score_sat", score_bcd, 12'h999);

        if (!aborted) play_block(0, -1);
        cyc(3);
        check("over_misses", misses, 3);
        check("over_flag",   game_over, 1);

        base = xfer_cnt;
        tap  = '1;
        cyc(3);
        tap  = '0;
        cyc(3);
        tap  = 4'b0101;
        cyc(30);
        tap  = '0;
        check("over_no_draw", xfer_cnt - base, 0);
        check("over_valid",   draw_valid, 0);
        check("over_score",   score_bcd, 12'h999);
        check("over_misses2", misses, 3);
        check("over_flag2",   game_over, 1);

        resetn = 1'b0;
        cyc(1);
        check("rst2_valid",  draw_valid, 0);
        check("rst2_score",  score_bcd, 0);
        check("rst2_misses", misses, 0);
        check("rst2_over",   game_over, 0);
        resetn     = 1'b1;
        draw_ready = 1'b0;
        tick       = 1'b0;
        cyc(1);
        check("respawn", {draw_valid, draw_x, draw_y, draw_colour}, {1'b1, 8'd30, 7'd0, 3'b111});
        cyc(2);
        resetn = 1'b0;
        cyc(1);
        check("midreq_drop", draw_valid, 0);
        resetn = 1'b1;
        cyc(1);
        check("midreq_spawn", {draw_valid, draw_x, draw_y, draw_colour}, {1'b1, 8'd30, 7'd0, 3'b111});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
